m_mac_unit: RTL and testbench
=============================

M_MAC_UNIT -- requirements
Module: m_mac_unit

Interface
REQ-001 Parameter CGES, default 7, number of coefficient taps and samples per calculation.
REQ-002 Parameter DW, default 16, signed sample and coefficient width.
REQ-003 Derived constant AW = $clog2(CGES); ACCW = 2*DW + AW.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cal  input  1  calculation enable from the control FSM; high for the whole run.
REQ-007 fin  output  1  one-cycle pulse, calculation complete and result delivered.
REQ-008 busy  output  1  high in RUN or OUT.
REQ-009 coef_we  input  1  coefficient write strobe.
REQ-010 coef_waddr  input  AW  coefficient write index.
REQ-011 coef_wdata  input  DW  signed coefficient write data.
REQ-012 s_valid  input  1  sample valid.
REQ-013 s_ready  output  1  sample ready.
REQ-014 s_data  input  DW  signed sample.
REQ-015 r_valid  output  1  result valid.
REQ-016 r_ready  input  1  result ready.
REQ-017 r_data  output  ACCW  signed accumulated result.

Function
REQ-018 FSM states: IDLE, RUN, OUT, FIN.
REQ-019 IDLE: s_ready=0, r_valid=0; cal=1 -> RUN next cycle with acc=0 and idx=0.
REQ-020 RUN: s_ready=1; on s_valid&&s_ready, acc <= acc + coef[idx]*s_data (signed, full ACCW width, no truncation) and idx <= idx+1.
REQ-021 RUN: the accept at idx=CGES-1 -> OUT next cycle; idx does not wrap past CGES-1.
REQ-022 OUT: r_valid=1, r_data=acc, both held stable until r_ready=1; the handshake cycle -> FIN.
REQ-023 FIN: fin=1 for exactly one cycle, then IDLE; r_valid=0 in FIN.
REQ-024 cal=0 in RUN or OUT: abort to IDLE next cycle, acc cleared, no r_valid, no fin.
REQ-025 cal ignored in FIN; a new run needs cal high in IDLE (cal still high after FIN starts the next run).
REQ-026 Coefficient write accepted only in IDLE; coef_we in RUN, OUT or FIN is ignored.
REQ-027 Write with coef_waddr >= CGES is ignored.
REQ-028 Write in the same IDLE cycle as cal rising is accepted, and the new value is used by that run.
REQ-029 Sample-to-result latency: r_valid rises the cycle after the last sample accept.
REQ-030 Minimum run: CGES cycles in RUN, 1 in OUT, 1 in FIN.

Reset
REQ-031 reset_n low asynchronously forces IDLE, acc=0, idx=0, all coefficients 0, fin=0, busy=0, s_ready=0, r_valid=0, r_data=0.
REQ-032 Reset mid-run discards the run; no fin is produced after release.

Structure
REQ-033 Package m_mac_pkg holds the state enum and the AW/ACCW width functions.
REQ-034 Sub-module m_coef_rf: CGES x DW register file, async reset, one write port and one combinational read port.

Verification
REQ-035 Coefs all 1, samples 1..7, r_ready=1 -> r_data=28 one cycle after the 7th accept; fin pulses once, 1 cycle later.
REQ-036 Coefs all -32768, samples all -32768 -> r_data=7516192768, no overflow.
REQ-037 Coefs 0..6, s_valid toggled every other cycle -> r_data=dot product 0*s0+...+6*s6; idx advances only on accepts.
REQ-038 r_ready low for 10 cycles in OUT -> r_valid and r_data stable, fin=0 until the handshake.
REQ-039 cal dropped after 3 accepts -> IDLE, no r_valid or fin; the next full run with samples 1..7 and coefs 1 gives 28.
REQ-040 reset_n low mid-RUN -> outputs zero immediately, coefficients read 0; coef_we during RUN leaves the coefficients unchanged.

Source files
------------

// File: rtl/m_mac_pkg.sv
// Shared types and width helpers for the coefficient multiply-accumulate unit.
// The width helpers are used by the interface, the top and the register file.
package m_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2,
        ST_FIN  = 2'd3
    } mac_state_e;

    // A single tap still needs one index bit, so AW never collapses to zero.
    function automatic int aw_f(input int cges);
        return (cges > 1) ? $clog2(cges) : 1;
    endfunction

    function automatic int accw_f(input int dw, input int cges);
        return 2 * dw + aw_f(cges);
    endfunction

endpackage

// File: rtl/m_mac_unit_if.sv
// Coefficient write port, sample stream and result stream of the MAC unit.
// The master drives writes, samples and r_ready; the slave (the MAC) drives the rest.
interface m_mac_unit_if
    import m_mac_pkg::*;
#(
    parameter int CGES = 7,
    parameter int DW   = 16
);
    localparam int AW   = aw_f(CGES);
    localparam int ACCW = accw_f(DW, CGES);

    // Both streams use valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both high; a raised valid holds its data stable
    // until that edge, and ready may be raised or lowered at any time.
    logic            coef_we;
    logic [AW-1:0]   coef_waddr;
    logic [DW-1:0]   coef_wdata;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            r_valid;
    logic            r_ready;
    logic [ACCW-1:0] r_data;

    modport master (
        output coef_we, coef_waddr, coef_wdata,
        output s_valid, s_data,
        input  s_ready,
        input  r_valid, r_data,
        output r_ready
    );

    modport slave (
        input  coef_we, coef_waddr, coef_wdata,
        input  s_valid, s_data,
        output s_ready,
        output r_valid, r_data,
        input  r_ready
    );

endinterface

// File: rtl/m_coef_rf.sv
// CGES x DW coefficient register file: one synchronous write port,
// one combinational read port, all entries cleared by the async reset.
module m_coef_rf
    import m_mac_pkg::*;
#(
    parameter int CGES = 7,
    parameter int DW   = 16,
    parameter int AW   = aw_f(CGES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [CGES];
    logic          wr_hit;
    logic          rd_hit;

    // Addresses past the last tap exist in the index space but map to nothing.
    assign wr_hit = we_i && (int'(waddr_i) < CGES);
    assign rd_hit = (int'(raddr_i) < CGES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CGES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rd_hit ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/m_mac_unit.sv
// Multiply-accumulate of CGES signed samples against stored coefficients,
// sequenced by cal and delivering one full-width result per run.
module m_mac_unit
    import m_mac_pkg::*;
#(
    parameter int CGES = 7,
    parameter int DW   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cal,
    output logic        fin,
    output logic        busy,
    output mac_state_e  dbg_state_o,
    m_mac_unit_if.slave bus
);

    localparam int AW   = aw_f(CGES);
    localparam int ACCW = accw_f(DW, CGES);
    localparam logic [AW-1:0] LAST_IDX = AW'(CGES - 1);

    mac_state_e             state_q, state_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          idx_q, idx_d;

    logic [DW-1:0]          coef_rd;
    logic signed [2*DW-1:0] prod;
    logic                   coef_wr_en;
    logic                   s_fire;

    // Coefficients are frozen for the duration of a run.
    assign coef_wr_en = bus.coef_we && (state_q == ST_IDLE);

    m_coef_rf #(
        .CGES (CGES),
        .DW   (DW),
        .AW   (AW)
    ) u_coef_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (coef_wr_en),
        .waddr_i (bus.coef_waddr),
        .wdata_i (bus.coef_wdata),
        .raddr_i (idx_q),
        .rdata_o (coef_rd)
    );

    assign prod   = $signed(coef_rd) * $signed(bus.s_data);
    assign s_fire = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        bus.s_ready = 1'b0;
        bus.r_valid = 1'b0;
        fin         = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                idx_d = '0;
                if (cal) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                // Dropping cal wins over a simultaneous sample; the run is discarded.
                if (!cal) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    idx_d   = '0;
                end else if (s_fire) begin
                    acc_d = acc_q + ACCW'(prod);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_OUT: begin
                bus.r_valid = 1'b1;
                busy        = 1'b1;
                if (!cal) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    idx_d   = '0;
                end else if (bus.r_ready) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                fin     = 1'b1;
                state_d = ST_IDLE;
                acc_d   = '0;
                idx_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.r_data  = (state_q == ST_OUT) ? acc_q : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_m_mac_unit.sv
// Self-checking bench for m_mac_unit: a table of full runs plus hand-written
// abort, reset, write-timing and back-to-back sequences, checked via a result queue.
module tb_m_mac_unit;
    import m_mac_pkg::*;

    localparam int CGES = 7;
    localparam int DW   = 16;
    localparam int ACCW = accw_f(DW, CGES);
    localparam int NV   = 7;

    typedef struct packed {
        logic [CGES-1:0][DW-1:0] coef;
        logic [CGES-1:0][DW-1:0] samp;
        logic [63:0]             exp;
        logic                    gap;
        logic [7:0]              rdy_wait;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       cal;
    logic       fin;
    logic       busy;
    mac_state_e dbg_state;

    m_mac_unit_if #(.CGES(CGES), .DW(DW)) bus ();

    m_mac_unit #(.CGES(CGES), .DW(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cal         (cal),
        .fin         (fin),
        .busy        (busy),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    int          total;
    int          bad;
    logic [63:0] exp_q [$];
    vec_t        vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint model_dot(input vec_t v);
        longint s = 0;
        for (int i = 0; i < CGES; i++) begin
            s += longint'($signed(v.coef[i])) * longint'($signed(v.samp[i]));
        end
        return s;
    endfunction

    function automatic longint rdata_s();
        return longint'($signed(bus.r_data));
    endfunction

    // All tasks start and end on a falling edge.
    task automatic load_coefs(input vec_t v);
        for (int i = 0; i < CGES; i++) begin
            bus.coef_we    = 1'b1;
            bus.coef_waddr = 3'(i);
            bus.coef_wdata = v.coef[i];
            @(negedge clk);
        end
        bus.coef_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit load, input bit wr_at_cal,
                           input bit wr_in_run, input bit keep_cal);
        int          n;
        int          cyc;
        bit          tog;
        bit          acc_now;
        logic [63:0] held;
        n = 0; cyc = 0; tog = 1'b1;
        if (load) load_coefs(v);
        cal = 1'b1;
        if (wr_at_cal) begin
            bus.coef_we    = 1'b1;
            bus.coef_waddr = 3'd0;
            bus.coef_wdata = 16'd10;
        end
        @(negedge clk);
        bus.coef_we = 1'b0;
        chk("run_entry_busy", longint'(busy), 1);
        while (n < CGES && cyc < 200) begin
            bus.s_valid = v.gap ? tog : 1'b1;
            tog         = ~tog;
            bus.s_data  = v.samp[n];
            if (wr_in_run) begin
                bus.coef_we    = 1'b1;
                bus.coef_waddr = 3'(n);
                bus.coef_wdata = 16'd100;
            end
            acc_now = bus.s_valid && bus.s_ready;
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                n++;
                if (n == CGES) exp_q.push_back(v.exp);
            end
        end
        bus.s_valid = 1'b0;
        bus.coef_we = 1'b0;
        if (n < CGES) chk("sample_timeout", longint'(n), longint'(CGES));
        chk("r_valid_latency", longint'(bus.r_valid), 1);
        held = 64'(rdata_s());
        for (int k = 0; k < int'(v.rdy_wait); k++) begin
            @(negedge clk);
            chk("hold_r_valid", longint'(bus.r_valid), 1);
            chk("hold_r_data", rdata_s(), longint'(held));
            chk("hold_fin", longint'(fin), 0);
        end
        bus.r_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            chk("r_data", rdata_s(), longint'(exp_q.pop_front()));
        end
        @(negedge clk);
        bus.r_ready = 1'b0;
        chk("fin_pulse", longint'(fin), 1);
        chk("fin_r_valid", longint'(bus.r_valid), 0);
        if (!keep_cal) cal = 1'b0;
        @(negedge clk);
        chk("fin_one_cycle", longint'(fin), 0);
    endtask

    // Starts a run, accepts 'cnt' samples and returns with the DUT still in RUN.
    task automatic partial_run(input vec_t v, input int cnt);
        cal = 1'b1;
        @(negedge clk);
        for (int i = 0; i < cnt; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = v.samp[i];
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic watch_no_fin(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (fin || bus.r_valid) seen++;
        end
        chk(name, longint'(seen), 0);
    endtask

    initial begin
        vec_t v;
        total = 0; bad = 0;
        cal = 1'b0;
        bus.coef_we = 1'b0; bus.coef_waddr = '0; bus.coef_wdata = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.r_ready = 1'b0;

        for (int i = 0; i < CGES; i++) begin
            vecs[0].coef[i] = 16'd1;
            vecs[0].samp[i] = 16'(i + 1);
            vecs[1].coef[i] = 16'h8000;
            vecs[1].samp[i] = 16'h8000;
            vecs[2].coef[i] = 16'(i);
            vecs[3].coef[i] = 16'h7fff;
            vecs[3].samp[i] = 16'h7fff;
            vecs[4].samp[i] = 16'd10;
        end
        vecs[0].exp = 64'd28;          vecs[0].gap = 1'b0; vecs[0].rdy_wait = 8'd0;
        vecs[1].exp = 64'd7516192768;  vecs[1].gap = 1'b0; vecs[1].rdy_wait = 8'd0;
        vecs[2].samp = {16'h8000, 16'd1000, 16'hff38, 16'd100, 16'd7, 16'hfffb, 16'd3};
        vecs[2].exp = -64'sd192099;    vecs[2].gap = 1'b1; vecs[2].rdy_wait = 8'd0;
        vecs[3].exp = 64'd7515734023;  vecs[3].gap = 1'b0; vecs[3].rdy_wait = 8'd2;
        vecs[4].coef = {16'd8, 16'hfff9, 16'd6, 16'hfffb, 16'd4, 16'hfffd, 16'd2};
        vecs[4].exp = 64'd50;          vecs[4].gap = 1'b0; vecs[4].rdy_wait = 8'd10;
        for (int r = 5; r < NV; r++) begin
            for (int i = 0; i < CGES; i++) begin
                vecs[r].coef[i] = 16'($urandom_range(0, 65535));
                vecs[r].samp[i] = 16'($urandom_range(0, 65535));
            end
            vecs[r].exp      = 64'(model_dot(vecs[r]));
            vecs[r].gap      = 1'($urandom_range(0, 1));
            vecs[r].rdy_wait = 8'($urandom_range(0, 3));
        end

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_fin", longint'(fin), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_s_ready", longint'(bus.s_ready), 0);
        chk("reset_r_valid", longint'(bus.r_valid), 0);
        chk("reset_r_data", rdata_s(), 0);
        chk("reset_state", longint'(dbg_state), longint'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < NV; r++) begin
            run_vec(vecs[r], 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Abort after three accepts, then a clean full run.
        load_coefs(vecs[0]);
        partial_run(vecs[0], 3);
        cal = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_s_ready", longint'(bus.s_ready), 0);
        watch_no_fin("abort_no_result", 6);
        run_vec(vecs[0], 1'b0, 1'b0, 1'b0, 1'b0);

        // Writes during RUN/OUT are ignored, in this run and the next.
        run_vec(vecs[0], 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec(vecs[0], 1'b0, 1'b0, 1'b0, 1'b0);

        // Out-of-range index write does not disturb the taps.
        bus.coef_we = 1'b1; bus.coef_waddr = 3'd7; bus.coef_wdata = 16'd999;
        @(negedge clk);
        bus.coef_we = 1'b0;
        run_vec(vecs[0], 1'b0, 1'b0, 1'b0, 1'b0);

        // Write to tap 0 in the same cycle cal rises: 10*1 + 2+..+7 = 37.
        v = vecs[0];
        v.exp = 64'd37;
        run_vec(v, 1'b1, 1'b1, 1'b0, 1'b0);

        // cal held through FIN starts the next run straight away.
        run_vec(vecs[0], 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("back_to_back_busy", longint'(busy), 1);
        cal = 1'b0;
        @(negedge clk);
        chk("back_to_back_abort", longint'(busy), 0);

        // Reset mid-run: outputs clear at once and the taps read back as zero.
        v = vecs[0];
        for (int i = 0; i < CGES; i++) v.coef[i] = 16'd5;
        load_coefs(v);
        partial_run(vecs[0], 3);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_busy", longint'(busy), 0);
        chk("mid_reset_s_ready", longint'(bus.s_ready), 0);
        chk("mid_reset_r_data", rdata_s(), 0);
        chk("mid_reset_state", longint'(dbg_state), longint'(ST_IDLE));
        cal = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_fin("post_reset_no_fin", 8);
        v = vecs[0];
        v.exp = 64'd0;
        run_vec(v, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
